// File: rtl/dma_priority_arbiter_pkg.sv
// Shared constants and FSM state encoding for the DMA priority arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dma_arb_pkg;

  localparam int NUM_CH_DEFAULT = 4;
  localparam int CH_W = (NUM_CH_DEFAULT > 1) ? $clog2(NUM_CH_DEFAULT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    SERVICE  = 2'd2,
    RELEASE  = 2'd3
  } arbState_t;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Bundle of the request, bus-hold and acknowledge signals around the DMA arbiter.
// Latency: none (wiring only).
// Backpressure: HLDA/HRQ hold handshake; the arbiter waits on HLDA indefinitely.
interface dma_priority_arbiter_if import dma_arb_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEFAULT
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] maskReg;
  logic              controllerDisable;
  logic              rotatePriority;
  logic              HLDA;
  logic              xferDone;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic [CW-1:0]     grantCh;
  logic              grantValid;
  logic              serviceAbort;

  // Arbiter side.
  modport slave (
    input  DREQ, maskReg, controllerDisable, rotatePriority, HLDA, xferDone,
    output HRQ, DACK, grantCh, grantValid, serviceAbort
  );

  // Requester / CPU / timing-control side.
  modport master (
    output DREQ, maskReg, controllerDisable, rotatePriority, HLDA, xferDone,
    input  HRQ, DACK, grantCh, grantValid, serviceAbort
  );

endinterface

// File: rtl/dma_priority_arbiter_encoder.sv
// Rotate-and-find-first: first pending channel scanning upward from ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; winnerVld is simply low when nothing is pending.
module dma_priority_encoder import dma_arb_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CW-1:0]     ptr,
  output logic [CW-1:0]     winner,
  output logic              winnerVld
);

  int idx;

  // Scan channels ptr, ptr+1, ... (mod NUM_CH); the first pending one wins.
  always_comb begin
    winner    = '0;
    winnerVld = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!winnerVld && pending[idx]) begin
        winnerVld = 1'b1;
        winner    = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: requests bus hold, grants one channel per hold, optional rotation (DMA_ARB_ROTATE_EN).
// Latency: HRQ one cycle after a pending request; DACK the cycle after HLDA is sampled high.
// Backpressure: waits in HOLD_REQ/RELEASE for HLDA; losing HLDA mid-service aborts with a pulse.
module dma_priority_arbiter import dma_arb_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEFAULT
) (
  input logic                   CLK,
  input logic                   RESET_N,
  dma_priority_arbiter_if.slave bus
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_HOLD    = HOLD_REQ;
  localparam logic [1:0] ST_SERVICE = SERVICE;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic [NUM_CH-1:0] pending;
  logic              anyPending;
  logic [CW-1:0]     selPtr;
  logic [CW-1:0]     encWinner;
  logic              encVld;
  logic [CW-1:0]     winnerQ;
  logic              abortQ;
  logic              inService;

  assign pending    = bus.controllerDisable ? '0 : (bus.DREQ & ~bus.maskReg);
  assign anyPending = |pending;
  assign inService  = (state == ST_SERVICE);

`ifdef DMA_ARB_ROTATE_EN
  logic [CW-1:0] prioPtr;

  // Fixed mode always scans from channel 0; rotating mode scans from the pointer.
  assign selPtr = bus.rotatePriority ? prioPtr : '0;

  // After a completed (not aborted) rotating-mode service, the next channel becomes highest.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prioPtr <= '0;
    end else if (inService && bus.HLDA && bus.xferDone && bus.rotatePriority) begin
      prioPtr <= (winnerQ == CW'(NUM_CH - 1)) ? '0 : winnerQ + 1'b1;
    end
  end
`else
  logic unusedRotate;

  assign unusedRotate = bus.rotatePriority;
  assign selPtr       = '0;
`endif

  dma_priority_encoder #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) uEncoder (
    .pending   (pending),
    .ptr       (selPtr),
    .winner    (encWinner),
    .winnerVld (encVld)
  );

  // Hold-request / service sequencing; HLDA loss beats xferDone in SERVICE.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:    if (anyPending) stateNext = ST_HOLD;
      ST_HOLD: begin
        if (bus.HLDA)         stateNext = anyPending ? ST_SERVICE : ST_RELEASE;
        else if (!anyPending) stateNext = ST_IDLE;
      end
      ST_SERVICE: begin
        if (!bus.HLDA)         stateNext = ST_IDLE;
        else if (bus.xferDone) stateNext = ST_RELEASE;
      end
      ST_RELEASE: if (!bus.HLDA) stateNext = ST_IDLE;
      default:    stateNext = ST_IDLE;
    endcase
  end

  // State, latched winner and the one-cycle abort pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      winnerQ <= '0;
      abortQ  <= 1'b0;
    end else begin
      state  <= stateNext;
      abortQ <= inService && !bus.HLDA;
      if (state == ST_HOLD && bus.HLDA && encVld) winnerQ <= encWinner;
    end
  end

  // Outputs decode from state so reset clears them without waiting for a clock.
  always_comb begin
    bus.DACK = '0;
    if (inService) bus.DACK[winnerQ] = 1'b1;
  end

  assign bus.HRQ          = (state == ST_HOLD) || inService;
  assign bus.grantValid   = inService;
  assign bus.grantCh      = inService ? winnerQ : '0;
  assign bus.serviceAbort = abortQ;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Testbench for dma_priority_arbiter: directed scenarios plus randomized transactions.
// Latency: n/a.
// Backpressure: n/a.
module tb_dma_priority_arbiter;

  localparam int N  = 4;
  localparam int CW = 2;

`ifdef DMA_ARB_ROTATE_EN
  localparam bit ROT_BUILD = 1'b1;
`else
  localparam bit ROT_BUILD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  dma_priority_arbiter_if #(.NUM_CH(N)) dmaIf();

  dma_priority_arbiter #(.NUM_CH(N)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (dmaIf)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nPass   = 0;
  int refPtr  = 0;

  // Highest-priority channel has rank 0; rank counts upward from the priority base.
  function automatic int refWinner(logic [N-1:0] pend, bit rot);
    int base;
    int best;
    int bestRank;
    int rank;
    base     = (ROT_BUILD && rot) ? refPtr : 0;
    best     = -1;
    bestRank = N;
    for (int ch = 0; ch < N; ch++) begin
      rank = (ch - base + N) % N;
      if (pend[ch] && rank < bestRank) begin
        bestRank = rank;
        best     = ch;
      end
    end
    return best;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleInputs();
    dmaIf.DREQ              = '0;
    dmaIf.maskReg           = '0;
    dmaIf.controllerDisable = 1'b0;
    dmaIf.rotatePriority    = 1'b0;
    dmaIf.HLDA              = 1'b0;
    dmaIf.xferDone          = 1'b0;
  endtask

  task automatic applyReset();
    idleInputs();
    RESET_N = 1'b0;
    step();
    step();
    RESET_N = 1'b1;
    refPtr  = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    #3;
    nChecks++; if (dmaIf.HRQ !== 1'b0) $display("FAIL reset_hrq got %b want 0", dmaIf.HRQ); else nPass++;
    nChecks++; if (dmaIf.DACK !== 4'b0000) $display("FAIL reset_dack got %b want 0000", dmaIf.DACK); else nPass++;
    nChecks++; if (dmaIf.grantValid !== 1'b0) $display("FAIL reset_gvld got %b want 0", dmaIf.grantValid); else nPass++;
    nChecks++; if (dmaIf.grantCh !== 2'd0) $display("FAIL reset_gch got %0d want 0", dmaIf.grantCh); else nPass++;
    nChecks++; if (dmaIf.serviceAbort !== 1'b0) $display("FAIL reset_abort got %b want 0", dmaIf.serviceAbort); else nPass++;
    step();
    RESET_N = 1'b1;
    step();
    nChecks++; if (dmaIf.HRQ !== 1'b0) $display("FAIL reset_idle_hrq got %b want 0", dmaIf.HRQ); else nPass++;
  endtask

  task automatic test_fixed();
    applyReset();
    dmaIf.DREQ = 4'b0110;
    step();
    nChecks++; if (dmaIf.HRQ !== 1'b1) $display("FAIL fixed_hrq got %b want 1", dmaIf.HRQ); else nPass++;
    step();
    step();
    nChecks++; if (dmaIf.DACK !== 4'b0000) $display("FAIL fixed_hold_dack got %b want 0000", dmaIf.DACK); else nPass++;
    dmaIf.HLDA = 1'b1;
    step();
    nChecks++; if (dmaIf.DACK !== 4'b0010) $display("FAIL fixed_dack got %b want 0010", dmaIf.DACK); else nPass++;
    nChecks++; if (dmaIf.grantCh !== 2'd1) $display("FAIL fixed_gch got %0d want 1", dmaIf.grantCh); else nPass++;
    nChecks++; if (dmaIf.grantValid !== 1'b1) $display("FAIL fixed_gvld got %b want 1", dmaIf.grantValid); else nPass++;
    dmaIf.xferDone = 1'b1;
    step();
    dmaIf.xferDone = 1'b0;
    nChecks++; if (dmaIf.DACK !== 4'b0000) $display("FAIL fixed_done_dack got %b want 0000", dmaIf.DACK); else nPass++;
    nChecks++; if (dmaIf.HRQ !== 1'b0) $display("FAIL fixed_done_hrq got %b want 0", dmaIf.HRQ); else nPass++;
    dmaIf.HLDA = 1'b0;
    dmaIf.DREQ = '0;
    step();
  endtask

  task automatic test_mask();
    int bad;
    applyReset();
    dmaIf.DREQ    = 4'b0001;
    dmaIf.maskReg = 4'b0001;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dmaIf.HRQ !== 1'b0) bad++;
    end
    nChecks++; if (bad !== 0) $display("FAIL mask_hrq_quiet got %0d cycles with HRQ=1 want 0", bad); else nPass++;
    dmaIf.maskReg = 4'b0000;
    step();
    nChecks++; if (dmaIf.HRQ !== 1'b1) $display("FAIL mask_clear_hrq got %b want 1", dmaIf.HRQ); else nPass++;
    dmaIf.HLDA = 1'b1;
    step();
    nChecks++; if (dmaIf.DACK !== 4'b0001) $display("FAIL mask_dack got %b want 0001", dmaIf.DACK); else nPass++;
    dmaIf.xferDone = 1'b1;
    step();
    dmaIf.xferDone = 1'b0;
    dmaIf.HLDA     = 1'b0;
    dmaIf.DREQ     = '0;
    step();
  endtask

  task automatic test_withdraw();
    applyReset();
    dmaIf.DREQ = 4'b1000;
    step();
    nChecks++; if (dmaIf.HRQ !== 1'b1) $display("FAIL wd_hrq got %b want 1", dmaIf.HRQ); else nPass++;
    dmaIf.DREQ = 4'b0000;
    dmaIf.HLDA = 1'b1;
    step();
    nChecks++; if (dmaIf.DACK !== 4'b0000) $display("FAIL wd_dack got %b want 0000", dmaIf.DACK); else nPass++;
    nChecks++; if (dmaIf.HRQ !== 1'b0) $display("FAIL wd_release_hrq got %b want 0", dmaIf.HRQ); else nPass++;
    dmaIf.DREQ = 4'b1000;
    step();
    nChecks++; if (dmaIf.HRQ !== 1'b0) $display("FAIL wd_no_rereq got %b want 0", dmaIf.HRQ); else nPass++;
    dmaIf.DREQ = 4'b0000;
    dmaIf.HLDA = 1'b0;
    step();
    dmaIf.DREQ = 4'b1000;
    step();
    nChecks++; if (dmaIf.HRQ !== 1'b1) $display("FAIL wd_idle_rereq got %b want 1", dmaIf.HRQ); else nPass++;
    dmaIf.DREQ = 4'b0000;
    step();
  endtask

  task automatic test_rotate();
    int expOrder[6];
    int exp;
    if (ROT_BUILD) expOrder = '{0, 1, 2, 3, 0, 1};
    else           expOrder = '{0, 0, 0, 0, 0, 0};
    applyReset();
    dmaIf.rotatePriority = 1'b1;
    dmaIf.DREQ           = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      nChecks++; if (dmaIf.HRQ !== 1'b1) $display("FAIL rot_hrq[%0d] got %b want 1", k, dmaIf.HRQ); else nPass++;
      dmaIf.HLDA = 1'b1;
      step();
      exp = refWinner(4'b1111, 1'b1);
      nChecks++; if (dmaIf.grantCh !== CW'(expOrder[k]) || exp != expOrder[k])
        $display("FAIL rot_order[%0d] got %0d want %0d (model %0d)", k, dmaIf.grantCh, expOrder[k], exp); else nPass++;
      dmaIf.xferDone = 1'b1;
      step();
      dmaIf.xferDone = 1'b0;
      if (ROT_BUILD) refPtr = (exp + 1) % N;
      dmaIf.HLDA = 1'b0;
      step();
    end
    step();
    dmaIf.HLDA = 1'b1;
    step();
    exp = refWinner(4'b1111, 1'b1);
    nChecks++; if (dmaIf.grantCh !== CW'(ROT_BUILD ? 2 : 0)) $display("FAIL abort_pre_gch got %0d want %0d", dmaIf.grantCh, ROT_BUILD ? 2 : 0); else nPass++;
    // HLDA loss together with xferDone must take the abort path.
    dmaIf.HLDA     = 1'b0;
    dmaIf.xferDone = 1'b1;
    step();
    dmaIf.xferDone = 1'b0;
    nChecks++; if (dmaIf.serviceAbort !== 1'b1) $display("FAIL abort_pulse got %b want 1", dmaIf.serviceAbort); else nPass++;
    nChecks++; if (dmaIf.DACK !== 4'b0000) $display("FAIL abort_dack got %b want 0000", dmaIf.DACK); else nPass++;
    nChecks++; if (dmaIf.HRQ !== 1'b0) $display("FAIL abort_hrq got %b want 0", dmaIf.HRQ); else nPass++;
    step();
    nChecks++; if (dmaIf.serviceAbort !== 1'b0) $display("FAIL abort_width got %b want 0", dmaIf.serviceAbort); else nPass++;
    dmaIf.HLDA = 1'b1;
    step();
    nChecks++; if (dmaIf.grantCh !== CW'(exp)) $display("FAIL abort_ptr_kept got %0d want %0d", dmaIf.grantCh, exp); else nPass++;
    dmaIf.xferDone = 1'b1;
    step();
    dmaIf.xferDone = 1'b0;
    if (ROT_BUILD) refPtr = (exp + 1) % N;
    dmaIf.HLDA = 1'b0;
    dmaIf.DREQ = '0;
    step();
  endtask

  task automatic test_reset_mid();
    applyReset();
    dmaIf.rotatePriority = 1'b1;
    dmaIf.DREQ           = 4'b1111;
    step();
    dmaIf.HLDA = 1'b1;
    step();
    dmaIf.xferDone = 1'b1;
    step();
    dmaIf.xferDone = 1'b0;
    dmaIf.HLDA     = 1'b0;
    step();
    step();
    dmaIf.HLDA = 1'b1;
    step();
    nChecks++; if (dmaIf.grantCh !== CW'(ROT_BUILD ? 1 : 0)) $display("FAIL rstmid_pre_gch got %0d want %0d", dmaIf.grantCh, ROT_BUILD ? 1 : 0); else nPass++;
    #3;
    RESET_N = 1'b0;
    #1;
    nChecks++; if (dmaIf.DACK !== 4'b0000) $display("FAIL rstmid_dack got %b want 0000", dmaIf.DACK); else nPass++;
    nChecks++; if (dmaIf.HRQ !== 1'b0) $display("FAIL rstmid_hrq got %b want 0", dmaIf.HRQ); else nPass++;
    nChecks++; if (dmaIf.grantValid !== 1'b0) $display("FAIL rstmid_gvld got %b want 0", dmaIf.grantValid); else nPass++;
    step();
    nChecks++; if (dmaIf.serviceAbort !== 1'b0) $display("FAIL rstmid_no_abort got %b want 0", dmaIf.serviceAbort); else nPass++;
    dmaIf.HLDA = 1'b0;
    RESET_N    = 1'b1;
    refPtr     = 0;
    step();
    dmaIf.HLDA = 1'b1;
    step();
    nChecks++; if (dmaIf.grantCh !== 2'd0) $display("FAIL rstmid_ptr_home got %0d want 0", dmaIf.grantCh); else nPass++;
    dmaIf.xferDone = 1'b1;
    step();
    dmaIf.xferDone = 1'b0;
    if (ROT_BUILD) refPtr = 1;
    dmaIf.HLDA = 1'b0;
    dmaIf.DREQ = '0;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    logic [N-1:0] m;
    logic [N-1:0] pend;
    logic [N-1:0] expDack;
    bit           rot;
    int           exp;
    int           dly;
    int           svc;
    int           bad;
    for (int it = 0; it < 40; it++) begin
      rot = 1'($urandom_range(0, 1));
      do begin
        d = N'($urandom);
        m = N'($urandom);
      end while ((d & ~m) == '0);
      pend                 = d & ~m;
      dmaIf.DREQ           = d;
      dmaIf.maskReg        = m;
      dmaIf.rotatePriority = rot;
      if ($urandom_range(0, 3) == 0) begin
        dmaIf.controllerDisable = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
          step();
          if (dmaIf.HRQ !== 1'b0) bad++;
        end
        nChecks++; if (bad !== 0) $display("FAIL rnd_disable[%0d] got %0d cycles with HRQ=1 want 0", it, bad); else nPass++;
        dmaIf.controllerDisable = 1'b0;
      end
      step();
      nChecks++; if (dmaIf.HRQ !== 1'b1) $display("FAIL rnd_hrq[%0d] got %b want 1", it, dmaIf.HRQ); else nPass++;
      dly = $urandom_range(0, 2);
      for (int i = 0; i < dly; i++) step();
      exp     = refWinner(pend, rot);
      expDack = N'(1) << exp;
      dmaIf.HLDA = 1'b1;
      step();
      nChecks++; if (dmaIf.DACK !== expDack) $display("FAIL rnd_dack[%0d] got %b want %b", it, dmaIf.DACK, expDack); else nPass++;
      nChecks++; if (dmaIf.grantCh !== CW'(exp)) $display("FAIL rnd_gch[%0d] got %0d want %0d", it, dmaIf.grantCh, exp); else nPass++;
      svc = $urandom_range(0, 3);
      bad = 0;
      for (int i = 0; i < svc; i++) begin
        dmaIf.DREQ              = N'($urandom);
        dmaIf.maskReg           = N'($urandom);
        dmaIf.controllerDisable = 1'($urandom_range(0, 1));
        step();
        if (dmaIf.DACK !== expDack) bad++;
      end
      nChecks++; if (bad !== 0) $display("FAIL rnd_hold[%0d] got %0d cycles with DACK changed want 0", it, bad); else nPass++;
      if ($urandom_range(0, 3) == 0) begin
        dmaIf.HLDA     = 1'b0;
        dmaIf.xferDone = 1'($urandom_range(0, 1));
        step();
        dmaIf.xferDone = 1'b0;
        nChecks++; if (dmaIf.serviceAbort !== 1'b1 || dmaIf.DACK !== '0 || dmaIf.HRQ !== 1'b0)
          $display("FAIL rnd_abort[%0d] got abort=%b dack=%b hrq=%b want 1/0000/0", it, dmaIf.serviceAbort, dmaIf.DACK, dmaIf.HRQ); else nPass++;
        dmaIf.DREQ = '0;
        step();
      end else begin
        dmaIf.xferDone = 1'b1;
        step();
        dmaIf.xferDone = 1'b0;
        nChecks++; if (dmaIf.DACK !== '0 || dmaIf.HRQ !== 1'b0 || dmaIf.serviceAbort !== 1'b0)
          $display("FAIL rnd_done[%0d] got dack=%b hrq=%b abort=%b want 0000/0/0", it, dmaIf.DACK, dmaIf.HRQ, dmaIf.serviceAbort); else nPass++;
        if (ROT_BUILD && rot) refPtr = (exp + 1) % N;
        dmaIf.HLDA = 1'b0;
        dmaIf.DREQ = '0;
        step();
      end
      dmaIf.controllerDisable = 1'b0;
      dmaIf.maskReg           = '0;
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_mask();
    test_withdraw();
    test_rotate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d checks", nChecks);
    $fatal(1);
  end

endmodule
